pool_bin: RTL and testbench

2×2 stride-2 max-pool and binarize stage directly downstream of `conv`. Consumes the raster-ordered convolution results stream (`dout`/`ovalid`/`done` of `conv`), keeps one line of horizontal pair maxima, emits the pooled maximum plus its binarized bit. Layer 0 (`state`=0) pools 24×24 → 12×12; layer 1 (`state`=1) pools 8×8 → 4×4. Output feeds the next layer's `window` / FC input path.

---
 rtl/pool_bin.sv | 128 ++++++++++++
 tb/tb_pool_bin.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pool_bin.sv
// 2x2 stride-2 max-pool plus binarize of the raster conv result stream (24x24 or 8x8 maps).
// Latency: pooled result registered one cycle after the odd-row/odd-col input.
// No backpressure: input stalls only via ivalid gaps, downstream must take every ovalid pulse.
module pool_bin #(
    parameter int DW = 32,
    parameter int W0 = 24,
    parameter int W1 = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          state,
    input  logic [DW-1:0] din,
    input  logic          ivalid,
    input  logic          idone,
    input  logic [DW-1:0] thresh,
    output logic [DW-1:0] dout,
    output logic          dout_bit,
    output logic          ovalid,
    output logic          done,
    output logic          err
);

    localparam int LBD = W0 / 2;
    localparam int LBW = $clog2(LBD);

    // Raster position of the next incoming pixel and the layer latched at frame start
    logic [4:0]    col;
    logic [4:0]    row;
    logic          lstate;

    // Left pixel of the current horizontal pair, and one line of pair maxima
    logic [DW-1:0] hreg;
    logic [DW-1:0] lb [LBD];

    logic          frame_start;
    logic          cur_state;
    logic [4:0]    last_idx;
    logic          col_last;
    logic          row_last;
    logic          bad_done;
    logic          accept;
    logic          emit;
    logic [LBW-1:0] lb_idx;
    logic [DW-1:0] lb_rd;
    logic [DW-1:0] pm;
    logic [DW-1:0] res;

    // Position decode; the first pixel of a frame already uses the live state input
    always_comb begin
        frame_start = (col == 5'd0) && (row == 5'd0);
        cur_state   = frame_start ? state : lstate;
        last_idx    = cur_state ? 5'(W1 - 1) : 5'(W0 - 1);
        col_last    = (col == last_idx);
        row_last    = (row == last_idx);
        // A frame-end marker anywhere but the last pixel discards the frame
        bad_done    = ivalid && idone && !(col_last && row_last);
        accept      = ivalid && !bad_done;
        emit        = accept && row[0] && col[0];
        lb_idx      = col[LBW:1];
    end

    // Signed pair max and 2x2 block max
    always_comb begin
        lb_rd = lb[lb_idx];
        pm    = ($signed(din) > $signed(hreg)) ? din : hreg;
        res   = ($signed(lb_rd) > $signed(pm)) ? lb_rd : pm;
    end

    // Raster counters, layer latch and sticky framing error
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col    <= 5'd0;
            row    <= 5'd0;
            lstate <= 1'b0;
            err    <= 1'b0;
        end else if (ivalid) begin
            if (bad_done) begin
                err <= 1'b1;
                col <= 5'd0;
                row <= 5'd0;
            end else begin
                if (frame_start) begin
                    lstate <= state;
                end
                if (col_last) begin
                    col <= 5'd0;
                    row <= row_last ? 5'd0 : row + 5'd1;
                end else begin
                    col <= col + 5'd1;
                end
            end
        end
    end

    // Hold even-column pixels; even rows store pair maxima into the line buffer
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hreg <= '0;
            for (int i = 0; i < LBD; i++) begin
                lb[i] <= '0;
            end
        end else if (accept) begin
            if (!col[0]) begin
                hreg <= din;
            end else if (!row[0]) begin
                lb[lb_idx] <= pm;
            end
        end
    end

    // Registered pooled output; data holds between single-cycle valid pulses
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout     <= '0;
            dout_bit <= 1'b0;
            ovalid   <= 1'b0;
            done     <= 1'b0;
        end else begin
            ovalid <= emit;
            done   <= emit && col_last && row_last;
            if (emit) begin
                dout     <= res;
                dout_bit <= ($signed(res) >= $signed(thresh));
            end
        end
    end

endmodule

// File: tb/tb_pool_bin.sv
// Self-checking bench for pool_bin: drives conv-like frames, scoreboards pooled outputs.
// Expected values come from a direct 2x2 max over the driven image.
// Outputs are checked #1 after each rising edge, including exact one-cycle latency.
module tb_pool_bin;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          state = 1'b0;
    logic [DW-1:0] din = '0;
    logic          ivalid = 1'b0;
    logic          idone = 1'b0;
    logic [DW-1:0] thresh = '0;
    logic [DW-1:0] dout;
    logic          dout_bit;
    logic          ovalid;
    logic          done;
    logic          err;

    pool_bin #(.DW(DW), .W0(24), .W1(8)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .state    (state),
        .din      (din),
        .ivalid   (ivalid),
        .idone    (idone),
        .thresh   (thresh),
        .dout     (dout),
        .dout_bit (dout_bit),
        .ovalid   (ovalid),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] val;
        logic          bt;
        logic          dn;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    exp_t em;
    int   img[576];
    int   cyc = 0;
    int   done_cnt = 0;
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, $signed(got), $signed(exp), $time);
        end
    endtask

    // Output monitor: pops the scoreboard on every valid pulse
    always @(posedge clk) begin
        #1;
        cyc++;
        if (ovalid) begin
            if (done) done_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_ovalid", 1, 0);
            end else begin
                em = sb.pop_front();
                check("dout", dout, em.val);
                check("dout_bit", dout_bit, em.bt);
                check("done", done, em.dn);
                check("latency_cycle", cyc, em.cyc);
            end
        end else if (done) begin
            check("done_without_ovalid", 1, 0);
        end
    end

    // stop_kind: 0 none, 1 early idone at stop_at, 2 reset instead of input stop_at
    task automatic run_frame(input int side, input logic st, input int th, input bit gaps,
                             input int stop_at, input int stop_kind, input bit toggle);
        int n;
        int r;
        int c;
        int m;
        n = side * side;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    @(negedge clk);
                    ivalid = 1'b0;
                    idone  = 1'b1;
                    din    = $urandom;
                end
            end
            @(negedge clk);
            if (stop_kind == 2 && i == stop_at) begin
                ivalid = 1'b0;
                idone  = 1'b0;
                rstn   = 1'b0;
                #1;
                check("rst_dout", dout, 0);
                check("rst_dout_bit", dout_bit, 0);
                check("rst_ovalid", ovalid, 0);
                check("rst_done", done, 0);
                check("rst_err", err, 0);
                check("rst_sb_empty", sb.size(), 0);
                @(negedge clk);
                rstn = 1'b1;
                return;
            end
            ivalid = 1'b1;
            din    = img[i];
            thresh = th;
            idone  = (i == n - 1) || (stop_kind == 1 && i == stop_at);
            state  = (i == 0) ? st : (toggle ? ~state : st);
            if (stop_kind == 1 && i == stop_at) return;
            r = i / side;
            c = i % side;
            if ((r % 2 == 1) && (c % 2 == 1)) begin
                m = img[i];
                if (img[i - 1] > m) m = img[i - 1];
                if (img[i - side] > m) m = img[i - side];
                if (img[i - side - 1] > m) m = img[i - side - 1];
                sb.push_back('{val: m, bt: (m >= th), dn: (i == n - 1), cyc: cyc + 1});
            end
        end
    endtask

    task automatic idle(input int k);
        @(negedge clk);
        ivalid = 1'b0;
        idone  = 1'b0;
        repeat (k) @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int budget;
        budget = 0;
        while (sb.size() != 0 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check(tag, sb.size(), 0);
    endtask

    task automatic ramp();
        for (int i = 0; i < 576; i++) img[i] = i;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        #12;
        check("reset_dout", dout, 0);
        check("reset_dout_bit", dout_bit, 0);
        check("reset_ovalid", ovalid, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        @(negedge clk);
        rstn = 1'b1;
        idle(2);

        // Layer 0 ramp, continuous
        ramp();
        d0 = done_cnt;
        run_frame(24, 1'b0, 300, 1'b0, -1, 0, 1'b0);
        idle(3);
        drain("l0_ramp_drain");
        check("l0_ramp_done_count", done_cnt - d0, 1);
        check("l0_ramp_err", err, 0);

        // Layer 1 ramp with gaps (idone held high during gaps)
        d0 = done_cnt;
        run_frame(8, 1'b1, 30, 1'b1, -1, 0, 1'b0);
        idle(3);
        drain("l1_gaps_drain");
        check("l1_gaps_done_count", done_cnt - d0, 1);
        check("l1_gaps_err", err, 0);

        // Signed max: one -1 per 2x2 block at rotating positions, rest -5
        for (int i = 0; i < 64; i++) img[i] = -5;
        for (int b = 0; b < 16; b++) begin
            int br;
            int bc;
            int k;
            br = b / 4;
            bc = b % 4;
            k  = b % 4;
            img[(2 * br + k / 2) * 8 + 2 * bc + k % 2] = -1;
        end
        run_frame(8, 1'b1, -2, 1'b0, -1, 0, 1'b0);
        idle(3);
        drain("signed_drain");

        // Back-to-back: layer 0 with state toggling, then layer 1 with no idle cycle
        ramp();
        d0 = done_cnt;
        run_frame(24, 1'b0, 300, 1'b0, -1, 0, 1'b1);
        run_frame(8, 1'b1, 40, 1'b0, -1, 0, 1'b0);
        idle(3);
        drain("b2b_drain");
        check("b2b_done_count", done_cnt - d0, 2);

        // Early idone at input 100 of layer 0, then clean layer 1
        d0 = done_cnt;
        run_frame(24, 1'b0, 300, 1'b0, 100, 1, 1'b0);
        idle(3);
        drain("early_done_drain");
        check("early_done_err", err, 1);
        check("early_done_no_done", done_cnt - d0, 0);
        run_frame(8, 1'b1, 40, 1'b0, -1, 0, 1'b0);
        idle(3);
        drain("after_err_drain");
        check("after_err_done_count", done_cnt - d0, 1);
        check("err_sticky", err, 1);

        // Reset at input 300 of layer 0, then a fresh full layer 0 ramp
        run_frame(24, 1'b0, 300, 1'b0, 300, 2, 1'b0);
        idle(2);
        d0 = done_cnt;
        run_frame(24, 1'b0, 300, 1'b0, -1, 0, 1'b0);
        idle(3);
        drain("post_reset_drain");
        check("post_reset_done_count", done_cnt - d0, 1);
        check("post_reset_err", err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
